// File: rtl/lut_sched_pkg.sv
// Shared definitions for the LUT layer scheduler: FSM state encoding and
// width helpers used by the top level and the truth-table store.
package lut_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_WAIT,
        ST_DONE
    } sched_state_e;

    // Neuron counter width; a single neuron still needs one counter bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Table address width: {neuron index, entry}.
    function automatic int unsigned cfg_addr_width(input int unsigned n, input int unsigned in_bits);
        return $clog2(n) + in_bits;
    endfunction

endpackage

// File: rtl/lut_table_ram.sv
// Truth-table store shared by all neurons: one write port, one synchronous
// read port (latency 1). Contents are not reset.
module lut_table_ram
    import lut_sched_pkg::*;
#(
    parameter int unsigned NUM_NEURONS = 4,
    parameter int unsigned IN_BITS     = 8,
    parameter int unsigned OUT_BITS    = 2
) (
    input  logic                                                 clk,
    input  logic                                                 wr_en,
    input  logic [cfg_addr_width(NUM_NEURONS, IN_BITS)-1:0]      wr_addr,
    input  logic [OUT_BITS-1:0]                                  wr_data,
    input  logic [cfg_addr_width(NUM_NEURONS, IN_BITS)-1:0]      rd_addr,
    output logic [OUT_BITS-1:0]                                  rd_data
);

    localparam int unsigned DEPTH = NUM_NEURONS * (2 ** IN_BITS);

    logic [OUT_BITS-1:0] mem [DEPTH];

    // Write port plus registered read port; addresses beyond the last
    // neuron (non power-of-two neuron counts) are dropped on write.
    always_ff @(posedge clk) begin
        if (wr_en && (32'(wr_addr) < DEPTH)) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/lut_layer_scheduler.sv
// LUT layer scheduler: time-multiplexes NUM_NEURONS neurons onto one
// truth-table store, one read per cycle, results collected into out_data.
// Optional feature macro: LUT_SCHED_PERF_EN adds a saturating perf_count
// of completed output handshakes.
module lut_layer_scheduler
    import lut_sched_pkg::*;
#(
    parameter int unsigned NUM_NEURONS = 4,
    parameter int unsigned IN_BITS     = 8,
    parameter int unsigned OUT_BITS    = 2
) (
    input  logic                                            clk,
    input  logic                                            rst_n,
    input  logic                                            in_valid,
    output logic                                            in_ready,
    input  logic [NUM_NEURONS*IN_BITS-1:0]                  in_data,
    output logic                                            out_valid,
    input  logic                                            out_ready,
    output logic [NUM_NEURONS*OUT_BITS-1:0]                 out_data,
    input  logic                                            cfg_we,
    output logic                                            cfg_ready,
    input  logic [cfg_addr_width(NUM_NEURONS, IN_BITS)-1:0] cfg_addr,
    input  logic [OUT_BITS-1:0]                             cfg_data
`ifdef LUT_SCHED_PERF_EN
    ,
    output logic [31:0]                                     perf_count
`endif
);

    localparam int unsigned CNT_W  = cnt_width(NUM_NEURONS);
    localparam int unsigned ADDR_W = cfg_addr_width(NUM_NEURONS, IN_BITS);
    localparam logic [CNT_W-1:0] LAST_NEURON = CNT_W'(NUM_NEURONS - 1);

    sched_state_e                       state_q, state_d;
    logic [CNT_W-1:0]                   cnt_q, cnt_d;
    logic [NUM_NEURONS*IN_BITS-1:0]     hold_q, hold_d;
    logic                               rd_pend_q, rd_pend_d;
    logic [CNT_W-1:0]                   rd_idx_q, rd_idx_d;
    logic [NUM_NEURONS*OUT_BITS-1:0]    out_data_q, out_data_d;

    logic                               tbl_we;
    logic [IN_BITS-1:0]                 rd_entry;
    logic [ADDR_W-1:0]                  rd_addr;
    logic [OUT_BITS-1:0]                rd_data;

    lut_table_ram #(
        .NUM_NEURONS (NUM_NEURONS),
        .IN_BITS     (IN_BITS),
        .OUT_BITS    (OUT_BITS)
    ) u_table (
        .clk     (clk),
        .wr_en   (tbl_we),
        .wr_addr (cfg_addr),
        .wr_data (cfg_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // Next-state, datapath and handshake outputs.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hold_d     = hold_q;
        out_data_d = out_data_q;

        cfg_ready  = (state_q == ST_IDLE);
        in_ready   = (state_q == ST_IDLE) && !cfg_we;
        out_valid  = (state_q == ST_DONE);
        tbl_we     = (state_q == ST_IDLE) && cfg_we;

        rd_entry   = hold_q[cnt_q*IN_BITS +: IN_BITS];
        rd_addr    = (ADDR_W'(cnt_q) << IN_BITS) | ADDR_W'(rd_entry);

        // Read data returns one cycle after issue; remember which slot it fills.
        rd_pend_d  = (state_q == ST_RUN);
        rd_idx_d   = cnt_q;
        if (rd_pend_q) begin
            out_data_d[rd_idx_q*OUT_BITS +: OUT_BITS] = rd_data;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (!cfg_we && in_valid) begin
                    hold_d  = in_data;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (cnt_q == LAST_NEURON) begin
                    state_d = ST_WAIT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WAIT: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; table contents are deliberately not reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            hold_q     <= '0;
            rd_pend_q  <= 1'b0;
            rd_idx_q   <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hold_q     <= hold_d;
            rd_pend_q  <= rd_pend_d;
            rd_idx_q   <= rd_idx_d;
            out_data_q <= out_data_d;
        end
    end

    assign out_data = out_data_q;

`ifdef LUT_SCHED_PERF_EN
    logic [31:0] perf_q, perf_d;

    // Completed-result counter, saturating at all ones.
    always_comb begin
        perf_d = perf_q;
        if (out_valid && out_ready && (perf_q != '1)) begin
            perf_d = perf_q + 32'd1;
        end
    end

    // Performance counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_count = perf_q;
`endif

endmodule

// File: tb/tb_lut_layer_scheduler.sv
// Scoreboard bench for lut_layer_scheduler: stimulus pushes expected results
// computed from a per-neuron truth-table model; a negedge monitor pops and
// compares whenever the DUT presents out_valid.
module tb_lut_layer_scheduler;

    localparam int N  = 4;
    localparam int IB = 8;
    localparam int OB = 2;
    localparam int AW = $clog2(N) + IB;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [N*IB-1:0] in_data = '0;
    logic            out_valid;
    logic            out_ready;
    logic [N*OB-1:0] out_data;
    logic            cfg_we = 1'b0;
    logic            cfg_ready;
    logic [AW-1:0]   cfg_addr = '0;
    logic [OB-1:0]   cfg_data = '0;
    logic            ready_ctl = 1'b1;
    logic            rand_en = 1'b0;
    logic            rand_bit = 1'b1;
`ifdef LUT_SCHED_PERF_EN
    logic [31:0]     perf_count;
`endif

    assign out_ready = rand_en ? rand_bit : ready_ctl;

    lut_layer_scheduler #(
        .NUM_NEURONS (N),
        .IN_BITS     (IB),
        .OUT_BITS    (OB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .cfg_we    (cfg_we),
        .cfg_ready (cfg_ready),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data)
`ifdef LUT_SCHED_PERF_EN
        ,
        .perf_count(perf_count)
`endif
    );

    int          checks = 0;
    int          failures = 0;
    int unsigned cyc = 0;
    int unsigned handshakes = 0;

    logic [OB-1:0] model [N][1<<IB];

    typedef struct {
        logic [N*OB-1:0] data;
        int unsigned     acc;
    } exp_t;
    exp_t        sb[$];
    int unsigned acc_log[$];

    always @(posedge clk) cyc++;
    always @(posedge clk) begin
        #1;
        rand_bit = 1'($urandom_range(0, 1));
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [N*OB-1:0] ref_out(input logic [N*IB-1:0] v);
        logic [N*OB-1:0] r;
        for (int k = 0; k < N; k++) begin
            r[k*OB +: OB] = model[k][v[k*IB +: IB]];
        end
        return r;
    endfunction

    // Monitor: compare each presented result, then verify it stays put while stalled.
    logic            mon_seen = 1'b0;
    logic [N*OB-1:0] mon_hold;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            mon_seen = 1'b0;
        end else if (out_valid) begin
            if (!mon_seen) begin
                if (sb.size() == 0) begin
                    check("unexpected_out_valid", 64'(out_valid), 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("out_data", 64'(out_data), 64'(e.data));
                    check("latency", 64'(cyc - e.acc), 64'(N + 2));
                end
                mon_seen = 1'b1;
                mon_hold = out_data;
            end else begin
                check("stall_out_data", 64'(out_data), 64'(mon_hold));
                check("stall_cfg_ready", 64'(cfg_ready), 64'd0);
            end
            check("done_in_ready", 64'(in_ready), 64'd0);
            if (out_ready) begin
                mon_seen = 1'b0;
                handshakes++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input int n, input int e, input logic [OB-1:0] d);
        bit done = 0;
        cfg_we   = 1'b1;
        cfg_addr = AW'((n << IB) | e);
        cfg_data = d;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (cfg_ready) begin
                model[n][e] = d;
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        cfg_we = 1'b0;
        if (!done) check("cfg_write_timeout", 64'd0, 64'd1);
    endtask

    task automatic send_vec(input logic [N*IB-1:0] v, output int unsigned acc);
        bit done = 0;
        acc      = 0;
        in_valid = 1'b1;
        in_data  = v;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                acc = cyc;
                sb.push_back('{ref_out(v), cyc});
                acc_log.push_back(cyc);
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) check("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_out_valid();
        bit done = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (out_valid) done = 1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        if (!done) check("out_valid_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        bit done = 0;
        for (int i = 0; i < 1000 && !done; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !out_valid && cfg_ready) done = 1;
            @(posedge clk);
            #1;
        end
        if (!done) check("drain_timeout", 64'(sb.size()), 64'd0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        handshakes = 0;
        tick();
    endtask

    initial begin
        int unsigned     acc;
        int unsigned     wcyc;
        int              e;
        logic [OB-1:0]   nd;
        logic [N*IB-1:0] v;
        logic [N*IB-1:0] v029;

        v029 = {8'h00, 8'h5A, 8'hFF, 8'h00};

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_cfg_ready", 64'(cfg_ready), 64'd1);
        rst_n = 1'b1;
        tick();

        // Fill the whole table so every read is defined.
        for (int n = 0; n < N; n++)
            for (int k = 0; k < (1 << IB); k++)
                cfg_write(n, k, OB'($urandom));

        // Directed vector; a write pulsed during RUN must be ignored.
        cfg_write(0, 8'h00, 2'b01);
        cfg_write(1, 8'hFF, 2'b10);
        cfg_write(2, 8'h5A, 2'b11);
        cfg_write(3, 8'h00, 2'b00);
        send_vec(v029, acc);
        cfg_we   = 1'b1;
        cfg_addr = AW'(0);
        cfg_data = 2'b10;
        wait_out_valid();
        check("req029_out_data", 64'(out_data), 64'b00_11_10_01);
        check("req029_latency", 64'(cyc - acc), 64'd6);
        tick();
        cfg_we = 1'b0;
        drain();
        send_vec(v029, acc);
        drain();

        // Output stall for 5 cycles.
        ready_ctl = 1'b0;
        send_vec(N*IB'($urandom), acc);
        wait_out_valid();
        repeat (5) @(posedge clk);
        #1;
        ready_ctl = 1'b1;
        drain();

        // cfg_we and in_valid together in IDLE: write wins, accept next cycle.
        e  = int'($urandom_range(0, 255));
        nd = ~model[1][e];
        v  = N*IB'($urandom);
        v[1*IB +: IB] = IB'(e);
        cfg_we   = 1'b1;
        cfg_addr = AW'((1 << IB) | e);
        cfg_data = nd;
        in_valid = 1'b1;
        in_data  = v;
        @(negedge clk);
        check("collide_in_ready", 64'(in_ready), 64'd0);
        check("collide_cfg_ready", 64'(cfg_ready), 64'd1);
        model[1][e] = nd;
        wcyc = cyc;
        tick();
        cfg_we = 1'b0;
        send_vec(v, acc);
        check("collide_accept_cycle", 64'(acc), 64'(wcyc + 1));
        drain();

        // Reset while RUN is on neuron 2.
        send_vec(N*IB'($urandom), acc);
        for (int i = 0; i < 20 && cyc < acc + 3; i++) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrun_rst_out_valid", 64'(out_valid), 64'd0);
        check("midrun_rst_out_data", 64'(out_data), 64'd0);
        check("midrun_rst_cfg_ready", 64'(cfg_ready), 64'd1);
        void'(sb.pop_back());
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        send_vec(v029, acc);
        drain();

        // Back-to-back throughput, 10 vectors.
        pulse_reset();
        acc_log.delete();
        for (int i = 0; i < 10; i++) send_vec(N*IB'($urandom), acc);
        drain();
        for (int i = 1; i < acc_log.size(); i++)
            check("accept_spacing", 64'(acc_log[i] - acc_log[i-1]), 64'd7);
        check("handshake_count", 64'(handshakes), 64'd10);
`ifdef LUT_SCHED_PERF_EN
        check("perf_count", 64'(perf_count), 64'd10);
`endif

        // Randomised phase: random out_ready, interleaved table writes.
        rand_en = 1'b1;
        for (int i = 0; i < 25; i++) begin
            for (int w = 0; w < int'($urandom_range(0, 3)); w++)
                cfg_write(int'($urandom_range(0, N - 1)), int'($urandom_range(0, 255)), OB'($urandom));
            send_vec(N*IB'($urandom), acc);
        end
        drain();
        rand_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
